// File: rtl/ysyx_22040895_mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: FSM state encodings,
// RV64 opcode constants (plus the custom ecall/mret opcodes) and the
// instruction-class decoder used in DECODE.
package ysyx_22040895_mc_ctrl_pkg;

  // Encodings are visible on state_o for difftest, so values are fixed.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StError  = 3'd6
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpOp32   = 7'b0111011;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpEcall  = 7'h7F;
  localparam logic [6:0] OpMret   = 7'h7E;
  localparam logic [6:0] MFunc7   = 7'b0000001;

  typedef enum logic [3:0] {
    ClsAlu,
    ClsMul,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsSystem,
    ClsEcall,
    ClsMret,
    ClsFence
  } cls_e;

  // Anything unrecognised falls into the ALU class.
  function automatic cls_e classify(input logic [6:0] opcode, input logic [6:0] func7);
    cls_e cls;
    cls = ClsAlu;
    case (opcode)
      OpOp, OpOp32: if (func7 == MFunc7) cls = ClsMul;
      OpLoad:       cls = ClsLoad;
      OpStore:      cls = ClsStore;
      OpBranch:     cls = ClsBranch;
      OpSystem:     cls = ClsSystem;
      OpFence:      cls = ClsFence;
      OpEcall:      cls = ClsEcall;
      OpMret:       cls = ClsMret;
      default:      cls = ClsAlu;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/ysyx_22040895_wdt.sv
// Bus-hang watchdog counter.
//   clk, rst   : core clock, synchronous active-high reset
//   clear_i    : restart the count (state change)
//   count_en_i : a waiting cycle is being spent
//   expired_o  : this waiting cycle brings the count to all-ones
module ysyx_22040895_wdt #(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  // The count reaches all-ones at the edge ending the (2^W-1)-th wait cycle.
  localparam logic [TIMEOUT_W-1:0] LastWait = ~(TIMEOUT_W'(1));

  logic [TIMEOUT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      r_cnt <= '0;
    end else if (count_en_i) begin
      r_cnt <= r_cnt + TIMEOUT_W'(1);
    end
  end

  assign expired_o = count_en_i && (r_cnt == LastWait);

endmodule

// File: rtl/ysyx_22040895_mc_ctrl.sv
// Multi-cycle NPC sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB.
//   clk, rst        : core clock, synchronous active-high reset
//   opcode_i/func7_i: IDU fields, classified during DECODE
//   ifu_rvalid_i, exu_done_i, lsu_ready_i : unit handshakes
//   ifu_req_o, inst_we_o, exu_start_o, lsu_req_o, lsu_we_o : unit controls
//   rf_we_o, csr_we_o, pc_we_o, trap_o : WB-only write enables / redirect
//   err_o, state_o, instret_o : hang flag, debug state, retired count
module ysyx_22040895_mc_ctrl
  import ysyx_22040895_mc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode_i,
  input  logic [6:0]           func7_i,
  input  logic                 ifu_rvalid_i,
  input  logic                 exu_done_i,
  input  logic                 lsu_ready_i,
  output logic                 ifu_req_o,
  output logic                 inst_we_o,
  output logic                 exu_start_o,
  output logic                 lsu_req_o,
  output logic                 lsu_we_o,
  output logic                 rf_we_o,
  output logic                 csr_we_o,
  output logic                 pc_we_o,
  output logic                 trap_o,
  output logic                 err_o,
  output logic [2:0]           state_o,
  output logic [INSTRET_W-1:0] instret_o
);

  state_e               r_state, w_state_next;
  cls_e                 r_cls;
  logic                 r_exec_wait;  // past the first cycle of a multi-cycle EXEC
  logic [INSTRET_W-1:0] r_instret;
  logic                 w_wdt_en, w_wdt_clear, w_wdt_expired;

  assign w_wdt_en = (r_state == StFetch) || (r_state == StMem) ||
                    ((r_state == StExec) && (r_cls == ClsMul));
  assign w_wdt_clear = (w_state_next != r_state);

  ysyx_22040895_wdt #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_wdt (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (w_wdt_clear),
    .count_en_i (w_wdt_en),
    .expired_o  (w_wdt_expired)
  );

  // Handshakes are tested before the watchdog so a coinciding one wins.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   w_state_next = StFetch;
      StFetch: begin
        if (ifu_rvalid_i)       w_state_next = StDecode;
        else if (w_wdt_expired) w_state_next = StError;
      end
      StDecode: w_state_next = StExec;
      StExec: begin
        if (r_cls == ClsMul) begin
          if (exu_done_i)         w_state_next = StWb;
          else if (w_wdt_expired) w_state_next = StError;
        end else if ((r_cls == ClsLoad) || (r_cls == ClsStore)) begin
          w_state_next = StMem;
        end else begin
          w_state_next = StWb;
        end
      end
      StMem: begin
        if (lsu_ready_i)        w_state_next = StWb;
        else if (w_wdt_expired) w_state_next = StError;
      end
      StWb:     w_state_next = StFetch;
      StError:  w_state_next = StError;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cls       <= ClsAlu;
      r_exec_wait <= 1'b0;
      r_instret   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_exec_wait <= (r_state == StExec) && (w_state_next == StExec);
      if (r_state == StDecode) r_cls <= classify(opcode_i, func7_i);
      if (r_state == StWb) r_instret <= r_instret + INSTRET_W'(1);
    end
  end

  // Every output is forced low while rst is high, so a WB state caught by
  // reset cannot fire a write enable.
  always_comb begin
    ifu_req_o   = 1'b0;
    inst_we_o   = 1'b0;
    exu_start_o = 1'b0;
    lsu_req_o   = 1'b0;
    lsu_we_o    = 1'b0;
    rf_we_o     = 1'b0;
    csr_we_o    = 1'b0;
    pc_we_o     = 1'b0;
    trap_o      = 1'b0;
    err_o       = 1'b0;
    state_o     = 3'd0;
    instret_o   = '0;
    if (!rst) begin
      case (r_state)
        StFetch: begin
          ifu_req_o = 1'b1;
          inst_we_o = ifu_rvalid_i;
        end
        StExec: exu_start_o = !r_exec_wait;
        StMem: begin
          lsu_req_o = 1'b1;
          lsu_we_o  = (r_cls == ClsStore);
        end
        StWb: begin
          pc_we_o  = 1'b1;
          rf_we_o  = !(r_cls inside {ClsBranch, ClsStore, ClsEcall, ClsMret, ClsFence});
          csr_we_o = (r_cls == ClsSystem) || (r_cls == ClsEcall);
          trap_o   = (r_cls == ClsEcall) || (r_cls == ClsMret);
        end
        default: ;
      endcase
      err_o     = (r_state == StError);
      state_o   = r_state;
      instret_o = r_instret;
    end
  end

endmodule

// File: tb/tb_ysyx_22040895_mc_ctrl.sv
// Self-checking bench for ysyx_22040895_mc_ctrl. Inputs change and outputs are
// sampled 1 time unit after each falling edge. Expected behaviour is derived
// per instruction from its opcode class and the chosen handshake delays.
module tb_ysyx_22040895_mc_ctrl;

  localparam int unsigned TW = 4;
  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    opcode_i = '0;
  logic [6:0]    func7_i = '0;
  logic          ifu_rvalid_i = 1'b0;
  logic          exu_done_i = 1'b0;
  logic          lsu_ready_i = 1'b0;
  logic          ifu_req_o, inst_we_o, exu_start_o, lsu_req_o, lsu_we_o;
  logic          rf_we_o, csr_we_o, pc_we_o, trap_o, err_o;
  logic [2:0]    state_o;
  logic [IW-1:0] instret_o;
  logic [8:0]    outs;

  int checks = 0;
  int failures = 0;
  int exp_instret = 0;

  ysyx_22040895_mc_ctrl #(
    .TIMEOUT_W (TW),
    .INSTRET_W (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode_i     (opcode_i),
    .func7_i      (func7_i),
    .ifu_rvalid_i (ifu_rvalid_i),
    .exu_done_i   (exu_done_i),
    .lsu_ready_i  (lsu_ready_i),
    .ifu_req_o    (ifu_req_o),
    .inst_we_o    (inst_we_o),
    .exu_start_o  (exu_start_o),
    .lsu_req_o    (lsu_req_o),
    .lsu_we_o     (lsu_we_o),
    .rf_we_o      (rf_we_o),
    .csr_we_o     (csr_we_o),
    .pc_we_o      (pc_we_o),
    .trap_o       (trap_o),
    .err_o        (err_o),
    .state_o      (state_o),
    .instret_o    (instret_o)
  );

  always #5 clk = ~clk;

  assign outs = {ifu_req_o, inst_we_o, exu_start_o, lsu_req_o, lsu_we_o,
                 rf_we_o, csr_we_o, pc_we_o, trap_o};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_noise();
    opcode_i     = 7'($urandom);
    func7_i      = 7'($urandom);
    ifu_rvalid_i = 1'($urandom);
    exu_done_i   = 1'($urandom);
    lsu_ready_i  = 1'($urandom);
  endtask

  // One cycle of reset, then the IDLE cycle that follows it.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rand_noise();
    #1;
    chk("rst_outs", 64'(outs), 64'd0);
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_instret", 64'(instret_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rand_noise();
    #1;
    chk("idle_state", 64'(state_o), 64'd0);
    chk("idle_outs", 64'(outs), 64'd0);
    chk("idle_err", 64'(err_o), 64'd0);
    chk("idle_instret", 64'(instret_o), 64'd0);
    exp_instret = 0;
  endtask

  // Runs one instruction starting in its first FETCH cycle.
  // fw/xw/mw: wait cycles before rvalid / exu_done (M class) / lsu_ready.
  task automatic run_instr(input logic [6:0] op, input logic [6:0] f7,
                           input int fw, input int xw, input int mw);
    bit is_mul, is_mem, is_st, wr_rf, wr_csr, is_trap;
    int n_exec;
    is_mul  = ((op == 7'b0110011) || (op == 7'b0111011)) && (f7 == 7'b0000001);
    is_st   = (op == 7'b0100011);
    is_mem  = (op == 7'b0000011) || is_st;
    wr_rf   = !(op inside {7'b1100011, 7'b0100011, 7'h7F, 7'h7E, 7'b0001111});
    wr_csr  = (op == 7'b1110011) || (op == 7'h7F);
    is_trap = (op == 7'h7F) || (op == 7'h7E);
    n_exec  = is_mul ? xw + 1 : 1;

    for (int i = 0; i <= fw; i++) begin
      @(negedge clk);
      rand_noise();
      ifu_rvalid_i = (i == fw);
      #1;
      chk("fetch_state", 64'(state_o), 64'd1);
      chk("fetch_outs", 64'(outs), 64'({1'b1, i == fw, 7'b0}));
      chk("fetch_instret", 64'(instret_o), 64'(exp_instret));
    end

    @(negedge clk);
    rand_noise();
    opcode_i = op;
    func7_i  = f7;
    #1;
    chk("decode_state", 64'(state_o), 64'd2);
    chk("decode_outs", 64'(outs), 64'd0);

    for (int i = 0; i < n_exec; i++) begin
      @(negedge clk);
      rand_noise();
      if (is_mul) exu_done_i = (i == xw);
      #1;
      chk("exec_state", 64'(state_o), 64'd3);
      chk("exec_outs", 64'(outs), 64'({2'b0, i == 0, 6'b0}));
    end

    if (is_mem) begin
      for (int i = 0; i <= mw; i++) begin
        @(negedge clk);
        rand_noise();
        lsu_ready_i = (i == mw);
        #1;
        chk("mem_state", 64'(state_o), 64'd4);
        chk("mem_outs", 64'(outs), 64'({3'b0, 1'b1, is_st, 4'b0}));
      end
    end

    @(negedge clk);
    rand_noise();
    #1;
    chk("wb_state", 64'(state_o), 64'd5);
    chk("wb_outs", 64'(outs), 64'({5'b0, wr_rf, wr_csr, 1'b1, is_trap}));
    chk("wb_err", 64'(err_o), 64'd0);
    exp_instret = (exp_instret + 1) % (1 << IW);
  endtask

  logic [6:0] ops [12] = '{7'b0010011, 7'b0110011, 7'b0111011, 7'b0000011,
                           7'b0100011, 7'b1100011, 7'b1110011, 7'b0001111,
                           7'h7F, 7'h7E, 7'b0110111, 7'h55};

  initial begin
    logic [6:0] op, f7;
    do_reset();

    // Directed instructions
    run_instr(7'b0010011, 7'h00, 0, 0, 0);  // addi
    run_instr(7'b0000011, 7'h00, 0, 0, 3);  // load, ready 3 cycles in
    run_instr(7'b0100011, 7'h00, 0, 0, 3);  // store
    run_instr(7'b0110011, 7'h01, 0, 5, 0);  // mul, done after 5
    run_instr(7'h7F, 7'h00, 0, 0, 0);       // ecall
    run_instr(7'h7E, 7'h00, 0, 0, 0);       // mret
    run_instr(7'b1100011, 7'h00, 2, 0, 0);  // branch
    run_instr(7'b0001111, 7'h00, 0, 0, 0);  // fence
    run_instr(7'b1110011, 7'h00, 1, 0, 0);  // csrrw
    run_instr(7'b0111011, 7'h01, 0, 0, 0);  // mulw, done on first EXEC cycle
    run_instr(7'b0110011, 7'h20, 0, 0, 0);  // sub: exu_done ignored
    run_instr(7'h55, 7'h00, 0, 0, 0);       // unknown -> ALU
    run_instr(7'b0000011, 7'h00, 0, 0, 0);  // load, ready on first MEM cycle
    // Handshake on the cycle the watchdog saturates wins
    run_instr(7'b0000011, 7'h00, 14, 0, 14);
    run_instr(7'b0110011, 7'h01, 0, 14, 0);

    // Random instructions; instret wraps with the narrow counter
    for (int n = 0; n < 24; n++) begin
      op = ops[$urandom_range(0, 11)];
      f7 = ($urandom_range(0, 1) == 1) ? 7'h01 : 7'($urandom);
      run_instr(op, f7, $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
    end

    // Fetch hang: 15 waiting cycles then ERROR, absorbing
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rand_noise();
      ifu_rvalid_i = 1'b0;
      #1;
      chk("hang_fetch_state", 64'(state_o), 64'd1);
      chk("hang_fetch_err", 64'(err_o), 64'd0);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rand_noise();
      #1;
      chk("error_state", 64'(state_o), 64'd6);
      chk("error_err", 64'(err_o), 64'd1);
      chk("error_outs", 64'(outs), 64'd0);
    end
    do_reset();

    // Reset landing on the second MEM cycle of a load
    run_instr(7'b0010011, 7'h00, 0, 0, 0);
    @(negedge clk);
    rand_noise();
    ifu_rvalid_i = 1'b1;
    #1;
    chk("mr_fetch_state", 64'(state_o), 64'd1);
    @(negedge clk);
    rand_noise();
    opcode_i = 7'b0000011;
    func7_i  = 7'h00;
    #1;
    chk("mr_decode_state", 64'(state_o), 64'd2);
    @(negedge clk);
    rand_noise();
    #1;
    chk("mr_exec_state", 64'(state_o), 64'd3);
    @(negedge clk);
    rand_noise();
    lsu_ready_i = 1'b0;
    #1;
    chk("mr_mem_state", 64'(state_o), 64'd4);
    chk("mr_mem_outs", 64'(outs), 64'b000100000);
    @(negedge clk);
    rst = 1'b1;
    rand_noise();
    lsu_ready_i = 1'b1;
    #1;
    chk("mr_rst_outs", 64'(outs), 64'd0);
    chk("mr_rst_instret", 64'(instret_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rand_noise();
    #1;
    chk("mr_idle_state", 64'(state_o), 64'd0);
    chk("mr_idle_outs", 64'(outs), 64'd0);
    chk("mr_idle_instret", 64'(instret_o), 64'd0);
    exp_instret = 0;
    run_instr(7'b0010011, 7'h00, 0, 0, 0);
    @(negedge clk);
    rand_noise();
    #1;
    chk("final_instret", 64'(instret_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
